// File: rtl/mips_lite_pkg.sv
// Shared constants for the mips-lite datapath: opcode encodings and default widths.
package mips_lite_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 3;
  localparam logic [2:0]  OP_LDST    = 3'b111;

  // Load/save instructions write back to rs instead of rd.
  function automatic logic is_ldst(input logic [2:0] op);
    return op == OP_LDST;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write bitmap: issue sets a bit, write-back clears it, and the
// read addresses are flagged when they hit a register still in flight.
module reg_scoreboard
  import mips_lite_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_dst,
  input  logic                   clr_valid,
  input  logic [ADDR_W-1:0]      clr_dst,
  input  logic [ADDR_W-1:0]      rs_in,
  input  logic [ADDR_W-1:0]      rt_in,
  output logic [2**ADDR_W-1:0]   busy_vec,
  output logic                   hazard
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0] busy_next;
  logic                clr_hit_rs;
  logic                clr_hit_rt;

  // Issue is applied after clear so a new writer stays pending.
  always_comb begin
    busy_next = busy_vec;
    if (clr_valid) busy_next[clr_dst] = 1'b0;
    if (iss_valid) busy_next[iss_dst] = 1'b1;
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_vec <= '0;
    else     busy_vec <= busy_next;
  end

  // A register retiring this cycle is covered by the write-first bypass.
  always_comb begin
    clr_hit_rs = clr_valid && (clr_dst == rs_in);
    clr_hit_rt = clr_valid && (clr_dst == rt_in);
    hazard     = (busy_vec[rs_in] && !clr_hit_rs) ||
                 (busy_vec[rt_in] && !clr_hit_rt);
  end

endmodule

// File: rtl/regfile_bypass.sv
// Flop-based register file with write-first bypass on two read ports plus a
// save port, and a scoreboard tracking registers with pending writes.
module regfile_bypass
  import mips_lite_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           ALU_op,
  input  logic [ADDR_W-1:0]    rs_in,
  input  logic [ADDR_W-1:0]    rt_in,
  input  logic [ADDR_W-1:0]    rd_in,
  input  logic [DATA_W-1:0]    from_reg_src,
  input  logic                 reg_write,
  input  logic                 iss_valid,
  input  logic [ADDR_W-1:0]    iss_dst,
  output logic [DATA_W-1:0]    rs_out,
  output logic [DATA_W-1:0]    rt_out,
  output logic [DATA_W-1:0]    save_out,
  output logic                 hazard,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] wr_dst;
  logic              wr_en;
  logic              iss_en;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  // Hardwired-zero register swallows writes and issues, so it never changes.
  always_comb begin
    wr_dst  = is_ldst(ALU_op) ? rs_in : rd_in;
    wr_en   = reg_write && !((ZERO_REG != 0) && (wr_dst == '0));
    iss_en  = iss_valid && !((ZERO_REG != 0) && (iss_dst == '0));
    rs_data = (wr_en && (wr_dst == rs_in)) ? from_reg_src : regs[rs_in];
    rt_data = (wr_en && (wr_dst == rt_in)) ? from_reg_src : regs[rt_in];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      rs_out   <= '0;
      rt_out   <= '0;
      save_out <= '0;
    end else begin
      if (wr_en) regs[wr_dst] <= from_reg_src;
      rs_out   <= rs_data;
      rt_out   <= rt_data;
      save_out <= rs_data;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_en),
    .iss_dst   (iss_dst),
    .clr_valid (wr_en),
    .clr_dst   (wr_dst),
    .rs_in     (rs_in),
    .rt_in     (rt_in),
    .busy_vec  (busy_vec),
    .hazard    (hazard)
  );

endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 Parameter DATA_W, default 8, register width in bits.
REQ-002 Parameter ADDR_W, default 3, register address width; NUM_REGS = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 0; when 1, register 0 reads as zero, ignores writes and is never busy.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ALU_op  input  3  opcode of the write-back instruction; 3'b111 = load/save.
REQ-007 rs_in, rt_in, rd_in  input  ADDR_W each  read-A, read-B and arithmetic destination addresses.
REQ-008 from_reg_src  input  DATA_W  write-back data.
REQ-009 reg_write  input  1  write-back enable.
REQ-010 iss_valid  input  1  an instruction issues this cycle and will write iss_dst later.
REQ-011 iss_dst  input  ADDR_W  destination register of the issuing instruction.
REQ-012 rs_out, rt_out, save_out  output  DATA_W each  registered read data (save_out = value of register rs_in).
REQ-013 hazard  output  1  combinational: rs_in or rt_in names a busy register.
REQ-014 busy_vec  output  NUM_REGS  registered pending-write bitmap.

Function
REQ-015 Write destination SHALL be rs_in when ALU_op == 3'b111, otherwise rd_in; the write commits at the rising edge when reg_write = 1.
REQ-016 Read latency SHALL be exactly one cycle: outputs at edge N+1 reflect addresses sampled at edge N.
REQ-017 Reads SHALL be write-first: if the write destination equals a read address in the same cycle, that output SHALL take from_reg_src, not the old value.
REQ-018 Read outputs SHALL update every cycle out of reset, regardless of reg_write.
REQ-019 issue with iss_valid = 1 SHALL set busy_vec[iss_dst] at the next edge.
REQ-020 A write-back SHALL clear busy_vec[destination] at the next edge.
REQ-021 Simultaneous issue and write-back to the same register SHALL leave the bit set (issue wins; a new writer is pending).
REQ-022 Issue to an already-busy register SHALL keep the bit set; no counting of multiple writers.
REQ-023 hazard SHALL be computed from the current busy_vec and SHALL treat a register being cleared by a write-back this cycle as not busy (bypass covers it).
REQ-024 With ZERO_REG = 1, address 0 SHALL read 0 on all ports, writes and issues to it SHALL be ignored, busy_vec[0] SHALL stay 0.
REQ-025 Out-of-range addresses SHALL NOT exist: every ADDR_W value maps to a register.

Reset
REQ-026 rst = 1 SHALL asynchronously clear all NUM_REGS registers, rs_out, rt_out, save_out and busy_vec to 0.
REQ-027 A write or issue coinciding with reset assertion SHALL be discarded.
REQ-028 After rst deasserts, the first edge SHALL perform normal read/write/issue behaviour.

Structure
REQ-029 Package mips_lite_pkg SHALL hold OP_LDST = 3'b111 and default DATA_W/ADDR_W constants.
REQ-030 Busy-bit tracking SHALL be the sub-module reg_scoreboard (set/clear/hazard logic); storage and bypass stay in regfile_bypass.
REQ-031 Storage SHALL be flops (not inferred RAM) to support asynchronous reset and 2 reads + 1 save read per cycle.

Verification
REQ-032 Reset mid-operation: write 8'hA5 to r3, assert rst for one cycle -> rs_out = 0 and r3 reads 8'h00 afterwards; busy_vec = 0.
REQ-033 Mode select: ALU_op = 3'b111, rs_in = 2, rd_in = 5, data 8'h3C -> r2 = 8'h3C, r5 unchanged; ALU_op = 3'b000 same inputs -> r5 = 8'h3C.
REQ-034 Bypass: write 8'h77 to r4 while rs_in = rt_in = 4 -> rs_out = rt_out = save_out = 8'h77 next cycle.
REQ-035 Scoreboard: issue r6, next cycle rs_in = 6 -> hazard = 1; write-back r6 -> hazard = 0 that cycle, busy_vec[6] = 0 next; simultaneous issue+write r6 -> busy_vec[6] = 1.
REQ-036 ZERO_REG = 1: write 8'hFF to r0, issue r0 -> rs_out = 0, busy_vec[0] = 0, hazard = 0.
REQ-037 Generic widths: DATA_W = 16, ADDR_W = 4, write 16'hBEEF to r15 -> reads 16'hBEEF; all other registers 0.
